// File: rtl/mips_store_monitor_if.sv
// Purpose : data-memory write port of the single-cycle MIPS core, grouped
//           so that the core and the store monitor share one bundle.
// Signals : memwrite  - data-memory write enable
//           dataaddr  - data-memory byte address
//           writedata - data-memory write data
// Modports: master (core side, drives the port), slave (monitor side)
interface mips_store_monitor_if;
  logic        memwrite;
  logic [31:0] dataaddr;
  logic [31:0] writedata;

  modport master (output memwrite, output dataaddr, output writedata);
  modport slave  (input  memwrite, input  dataaddr, input  writedata);
endinterface

// File: rtl/mips_store_monitor.sv
// Purpose : watches every store issued by the single-cycle MIPS core and
//           reaches a pass/fail verdict. A store of PASS_DATA to PASS_ADDR
//           passes, stores to SCRATCH_ADDR are tolerated, any other store
//           fails. A cycle budget bounds the run (timeout verdict).
// Ports   : clk, reset (synchronous, active-high)
//           bus         - core data-memory write port (slave side)
//           done/pass/fail/timeout - registered verdict flags
//           store_count - stores seen while running (saturating)
//           cycle_count - running cycles elapsed (saturating)
//           last_addr/last_data - most recent observed store
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_RUN  | program running; stores and the cycle budget are evaluated
// ST_PASS | pass store seen; terminal until reset
// ST_FAIL | illegal store seen; terminal until reset
// ST_TOUT | cycle budget ran out without a verdict; terminal until reset
module mips_store_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd84,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd80,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_store_monitor_if.slave   bus,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [CNT_W-1:0]      store_count,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [31:0]           last_addr,
  output logic [31:0]           last_data
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TOUT = 2'd3
  } state_t;

  // Compared at 32 bits so a narrow counter can never alias the budget.
  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] store_count_q, store_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [31:0]      last_addr_q, last_addr_d;
  logic [31:0]      last_data_q, last_data_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;

  logic             at_last_cycle;
  logic             is_pass_store;
  logic             is_scratch_store;

  assign at_last_cycle    = (32'(cycle_count_q) == LAST_CYCLE);
  assign is_pass_store    = (bus.dataaddr == PASS_ADDR) && (bus.writedata == PASS_DATA);
  assign is_scratch_store = (bus.dataaddr == SCRATCH_ADDR);

  always_comb begin
    state_d       = state_q;
    store_count_d = store_count_q;
    cycle_count_d = cycle_count_q;
    last_addr_d   = last_addr_q;
    last_data_d   = last_data_q;

    if (state_q == ST_RUN) begin
      if (cycle_count_q != {CNT_W{1'b1}}) begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
      end

      // A store on the last budgeted cycle takes priority over the timeout.
      if (bus.memwrite) begin
        if (store_count_q != {CNT_W{1'b1}}) begin
          store_count_d = store_count_q + CNT_W'(1);
        end
        last_addr_d = bus.dataaddr;
        last_data_d = bus.writedata;
        if (is_pass_store) begin
          state_d = ST_PASS;
        end else if (!is_scratch_store) begin
          state_d = ST_FAIL;
        end
      end else if (at_last_cycle) begin
        state_d = ST_TOUT;
      end
    end

    // Flags are decoded from the next state so they land in flops together
    // with the state itself.
    done_d    = (state_d != ST_RUN);
    pass_d    = (state_d == ST_PASS);
    fail_d    = (state_d == ST_FAIL) || (state_d == ST_TOUT);
    timeout_d = (state_d == ST_TOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      store_count_q <= '0;
      cycle_count_q <= '0;
      last_addr_q   <= '0;
      last_data_q   <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      store_count_q <= store_count_d;
      cycle_count_q <= cycle_count_d;
      last_addr_q   <= last_addr_d;
      last_data_q   <= last_data_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign store_count = store_count_q;
  assign cycle_count = cycle_count_q;
  assign last_addr   = last_addr_q;
  assign last_data   = last_data_q;

endmodule
